// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that lets NUM_REQ producers share the write port
// of one synchronous FIFO. It registers the chosen word onto the FIFO write
// port, throttles on full/almostfull, and checks every issued write against
// the FIFO's acknowledge so that lost writes are counted and flagged.
//
// Handshake: a producer raises req[i] with its word on req_data and holds both
// until it sees gnt[i]. gnt[i] is a one-cycle pulse that coincides with the
// FIFO write of that word; the producer may change data or drop req after it.
// Dropping req before gnt simply withdraws the request with no side effects.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic                          fifo_wr_en,
   input  logic                          fifo_full,
   input  logic                          fifo_almostfull,
   input  logic                          fifo_wr_ack,
   input  logic                          fifo_overflow,
   output logic                          err_lost,
   output logic [CNT_WIDTH-1:0]          lost_cnt,
   output logic [CNT_WIDTH-1:0]          wr_cnt,
   output logic [1:0]                    fsm_state
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   state_t                  state;
   logic [PTR_W-1:0]        ptr;
   logic [PTR_W-1:0]        pick_idx;
   logic [PTR_W-1:0]        ptr_next;
   logic [NUM_REQ-1:0]      eligible;
   logic [NUM_REQ-1:0]      pick_onehot;
   logic [DATA_WIDTH-1:0]   pick_data;
   logic                    found;
   logic                    any_eligible;
   logic                    can_issue;
   logic                    issue;
   logic                    in_flight;
   logic                    ack_ok;

   // Request masking and issue permission: a producer just granted sits out one
   // edge, and a write already heading into the last free slot blocks another.
   always_comb begin
      eligible     = req & ~gnt;
      any_eligible = |eligible;
      can_issue    = ~fifo_full & ~(fifo_almostfull & fifo_wr_en);
      issue        = can_issue & any_eligible;
   end

   // Round-robin pick: first eligible index at or above ptr, otherwise the
   // lowest eligible index (the wrap-around case).
   always_comb begin
      found       = 1'b0;
      pick_idx    = '0;
      pick_onehot = '0;
      pick_data   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && eligible[i] && (i >= int'(ptr))) begin
            found          = 1'b1;
            pick_idx       = i[PTR_W-1:0];
            pick_onehot    = '0;
            pick_onehot[i] = 1'b1;
            pick_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && eligible[i]) begin
            found          = 1'b1;
            pick_idx       = i[PTR_W-1:0];
            pick_onehot    = '0;
            pick_onehot[i] = 1'b1;
            pick_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Pointer advance: the winner's successor becomes top priority.
   always_comb begin
      if (int'(pick_idx) == NUM_REQ - 1) begin
         ptr_next = '0;
      end else begin
         ptr_next = pick_idx + 1'b1;
      end
   end

   // Arbitration FSM with registered FIFO write port, grant and pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         gnt          <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_data_in <= '0;
      end else begin
         gnt        <= issue ? pick_onehot : '0;
         fifo_wr_en <= issue;
         if (issue) begin
            fifo_data_in <= pick_data;
            ptr          <= ptr_next;
         end
         case (state)
            ST_IDLE: begin
               if (issue) begin
                  state <= ST_ISSUE;
               end else if (any_eligible) begin
                  state <= ST_STALL;
               end
            end
            ST_ISSUE: begin
               if (issue) begin
                  state <= ST_ISSUE;
               end else if (any_eligible) begin
                  state <= ST_STALL;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_STALL: begin
               if (issue) begin
                  state <= ST_ISSUE;
               end else if (!any_eligible) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // A response that claims both acceptance and overflow is not trusted as a
   // successful write.
   assign ack_ok = fifo_wr_ack & ~fifo_overflow;

   // Ack checking: the cycle after each write the FIFO must acknowledge it;
   // anything else counts as a lost write. Responses outside that window are
   // ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_flight <= 1'b0;
         wr_cnt    <= '0;
         lost_cnt  <= '0;
         err_lost  <= 1'b0;
      end else begin
         in_flight <= fifo_wr_en;
         if (in_flight) begin
            if (ack_ok) begin
               if (wr_cnt != '1) begin
                  wr_cnt <= wr_cnt + 1'b1;
               end
            end else begin
               if (lost_cnt != '1) begin
                  lost_cnt <= lost_cnt + 1'b1;
               end
               err_lost <= 1'b1;
            end
         end
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a depth-8 FIFO model answers the write port, a
// scoreboard holds the expected {gnt, data} of each write in issue order.
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 16;
   localparam int CW      = 4;
   localparam int DEPTH   = 8;
   localparam int W       = NUM_REQ + DW;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_STALL = 2'd2;

   logic                   clk;
   logic                   rst;
   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ*DW-1:0]  req_data;
   logic [NUM_REQ-1:0]     gnt;
   logic [DW-1:0]          fifo_data_in;
   logic                   fifo_wr_en;
   logic                   fifo_full;
   logic                   fifo_almostfull;
   logic                   fifo_wr_ack;
   logic                   fifo_overflow;
   logic                   err_lost;
   logic [CW-1:0]          lost_cnt;
   logic [CW-1:0]          wr_cnt;
   logic [1:0]             fsm_state;

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .req_data       (req_data),
      .gnt            (gnt),
      .fifo_data_in   (fifo_data_in),
      .fifo_wr_en     (fifo_wr_en),
      .fifo_full      (fifo_full),
      .fifo_almostfull(fifo_almostfull),
      .fifo_wr_ack    (fifo_wr_ack),
      .fifo_overflow  (fifo_overflow),
      .err_lost       (err_lost),
      .lost_cnt       (lost_cnt),
      .wr_cnt         (wr_cnt),
      .fsm_state      (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model
   int   fcnt;
   logic drain;
   logic force_lost;
   logic spur;
   logic ovf_seen;
   logic m_push;
   logic m_pop;

   assign fifo_full       = (fcnt == DEPTH);
   assign fifo_almostfull = (fcnt >= DEPTH - 1);
   assign m_push          = fifo_wr_en && !force_lost && (fcnt < DEPTH);
   assign m_pop           = drain && (fcnt > 0);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt          <= 0;
         fifo_wr_ack   <= 1'b0;
         fifo_overflow <= 1'b0;
         ovf_seen      <= 1'b0;
      end else begin
         fcnt          <= fcnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
         fifo_wr_ack   <= m_push | spur;
         fifo_overflow <= fifo_wr_en & ~m_push;
         if (fifo_wr_en && !force_lost && (fcnt == DEPTH)) ovf_seen <= 1'b1;
      end
   end

   // scoreboard
   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] pd[NUM_REQ];
   int            total;
   int            bad;
   int            wr_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && fifo_wr_en) begin
         wr_seen++;
         if (exp_q.size() == 0) begin
            chk("unexpected_wr", {12'd0, gnt, fifo_data_in}, 32'd0);
         end else begin
            chk("wr", {12'd0, gnt, fifo_data_in}, {12'd0, exp_q.pop_front()});
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic new_data();
      for (int i = 0; i < NUM_REQ; i++) begin
         pd[i] = 16'($urandom_range(0, 16'hFFFF));
         req_data[i*DW +: DW] = pd[i];
      end
   endtask

   task automatic push_exp(input int idx);
      logic [NUM_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      exp_q.push_back({oh, pd[idx]});
   endtask

   task automatic wait_grants(input int n, input int budget);
      int start;
      int k;
      start = wr_seen;
      k     = 0;
      while ((wr_seen - start < n) && (k < budget)) begin
         tick();
         k++;
      end
      if (wr_seen - start < n) chk("grant_timeout", wr_seen - start, n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0; wr_seen = 0;
      rst = 1'b1; req = '0; req_data = '0;
      drain = 1'b0; force_lost = 1'b0; spur = 1'b0;
      new_data();
      repeat (3) tick();

      // reset state
      chk("rst_gnt", gnt, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_data", fifo_data_in, 0);
      chk("rst_err", err_lost, 0);
      chk("rst_lost", lost_cnt, 0);
      chk("rst_wrcnt", wr_cnt, 0);
      chk("rst_state", fsm_state, S_IDLE);
      rst = 1'b0;

      // burst interrupted by asynchronous reset
      req = 4'b1111;
      push_exp(0); push_exp(1); push_exp(2);
      wait_grants(3, 10);
      @(posedge clk); #1;
      chk("burst_gnt3", gnt, 4'b1000);
      chk("burst_wrcnt", wr_cnt, 2);
      rst = 1'b1;
      #1;
      chk("async_gnt", gnt, 0);
      chk("async_wr_en", fifo_wr_en, 0);
      chk("async_data", fifo_data_in, 0);
      chk("async_wrcnt", wr_cnt, 0);
      chk("async_state", fsm_state, S_IDLE);
      req = '0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("post_rst_wrcnt", wr_cnt, 0);

      // round robin from pointer 0
      new_data();
      req = 4'b1111;
      push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
      wait_grants(5, 12);
      req = '0;
      repeat (4) tick();
      chk("rr_q_empty", exp_q.size(), 0);
      chk("rr_wrcnt", wr_cnt, 5);
      chk("rr_lost", lost_cnt, 0);
      chk("rr_state", fsm_state, S_IDLE);
      drain = 1'b1; repeat (8) tick(); drain = 1'b0;

      // single producer: grant every other cycle
      new_data();
      req = 4'b0100;
      for (int i = 0; i < 4; i++) push_exp(2);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk("single_gnt", gnt, (i % 2 == 1) ? 4'b0100 : 4'b0000);
      end
      req = '0;
      repeat (3) tick();
      chk("single_q_empty", exp_q.size(), 0);
      chk("single_wrcnt", wr_cnt, 9);
      drain = 1'b1; repeat (6) tick(); drain = 1'b0;

      // backpressure into a depth-8 FIFO, pointer now at 3
      new_data();
      req = 4'b1111;
      push_exp(3); push_exp(0); push_exp(1); push_exp(2);
      push_exp(3); push_exp(0); push_exp(1); push_exp(2);
      wait_grants(8, 20);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("full_hold", fifo_wr_en, 0);
      end
      chk("full_state", fsm_state, S_STALL);
      chk("full_level", fcnt, DEPTH);
      chk("full_no_ovf", ovf_seen, 0);
      chk("wrcnt_sat", wr_cnt, 15);
      push_exp(3);
      drain = 1'b1;
      tick();
      chk("still_full", fifo_wr_en, 0);
      drain = 1'b0;
      tick();
      chk("resume", fifo_wr_en, 1);
      tick();
      chk("refull", fifo_wr_en, 0);
      chk("refull_state", fsm_state, S_STALL);
      req = '0;
      drain = 1'b1; repeat (12) tick(); drain = 1'b0;
      chk("bp_state", fsm_state, S_IDLE);
      chk("bp_q_empty", exp_q.size(), 0);
      chk("bp_no_ovf", ovf_seen, 0);

      // lost write, then a good write: error stays sticky
      new_data();
      force_lost = 1'b1;
      req = 4'b0001;
      push_exp(0);
      wait_grants(1, 5);
      req = '0;
      repeat (3) tick();
      chk("lost_cnt", lost_cnt, 1);
      chk("lost_err", err_lost, 1);
      chk("lost_wrcnt", wr_cnt, 15);
      force_lost = 1'b0;
      req = 4'b0010;
      push_exp(1);
      wait_grants(1, 5);
      req = '0;
      repeat (3) tick();
      chk("sticky_err", err_lost, 1);
      chk("sticky_lost", lost_cnt, 1);

      // reset clears error; stray ack ignored; saturation from zero
      rst = 1'b1;
      tick();
      chk("clr_err", err_lost, 0);
      chk("clr_lost", lost_cnt, 0);
      chk("clr_wrcnt", wr_cnt, 0);
      tick();
      rst = 1'b0;
      tick();
      spur = 1'b1;
      tick();
      spur = 1'b0;
      repeat (3) tick();
      chk("stray_ack_wr", wr_cnt, 0);
      chk("stray_ack_lost", lost_cnt, 0);
      new_data();
      drain = 1'b1;
      req = 4'b1111;
      for (int i = 0; i < 20; i++) push_exp(i % 4);
      wait_grants(20, 40);
      req = '0;
      repeat (4) tick();
      drain = 1'b0;
      chk("sat_wrcnt", wr_cnt, 15);
      chk("sat_lost", lost_cnt, 0);
      chk("sat_q_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
